// File: rtl/hamming_pkg.sv
// Shared Hamming helpers for the streaming encoder and the future decoder.
// HAMMING_SECDED_EN adds one overall-parity bit to the codeword.
package hamming_pkg;

  localparam int unsigned MAX_POS = 64;

`ifdef HAMMING_SECDED_EN
  localparam int unsigned SECDED_W = 1;
`else
  localparam int unsigned SECDED_W = 0;
`endif

  // Smallest r with 2^r >= data_w + r + 1
  function automatic int unsigned calc_par_w(input int unsigned data_w);
    int unsigned r;
    r = 1;
    for (int unsigned i = 0; i < 7; i++) begin
      if ((32'd1 << r) < data_w + r + 1) r = r + 1;
    end
    return r;
  endfunction

  function automatic logic is_pow2(input int unsigned pos);
    return (pos != 0) && ((pos & (pos - 1)) == 0);
  endfunction

  // 1-based codeword position of data bit idx (non-power-of-two slots, ascending)
  function automatic int unsigned data_pos(input int unsigned idx);
    int unsigned cnt;
    int unsigned pos;
    cnt = 0;
    pos = 0;
    for (int unsigned p = 1; p < MAX_POS; p++) begin
      if (!is_pow2(p)) begin
        if (cnt == idx) pos = p;
        cnt = cnt + 1;
      end
    end
    return pos;
  endfunction

endpackage

// File: rtl/hamming_parity_gen.sv
// Combinational Hamming SEC codeword builder: places data bits and even parity
// bits at their positions (bit i holds position i+1).
module hamming_parity_gen
  import hamming_pkg::*;
#(
  parameter  int unsigned DATA_W = 4,
  localparam int unsigned PAR_W  = calc_par_w(DATA_W),
  localparam int unsigned POS_W  = DATA_W + PAR_W
) (
  input  logic [DATA_W-1:0] data,
  output logic [POS_W-1:0]  code_c
);

  logic par;

  always_comb begin
    code_c = '0;
    par    = 1'b0;
    for (int unsigned i = 0; i < DATA_W; i++) begin
      code_c[data_pos(i) - 1] = data[i];
    end
    // p_k covers every data position with bit k set
    for (int unsigned k = 0; k < PAR_W; k++) begin
      par = 1'b0;
      for (int unsigned i = 0; i < DATA_W; i++) begin
        if (((data_pos(i) >> k) & 1) != 0) par = par ^ data[i];
      end
      code_c[(1 << k) - 1] = par;
    end
  end

endmodule

// File: rtl/hamming_enc_stream.sv
// Two-stage streaming Hamming encoder with valid/ready flow control and an
// emitted-codeword counter. HAMMING_SECDED_EN appends an overall-parity bit.
module hamming_enc_stream
  import hamming_pkg::*;
#(
  parameter  int unsigned DATA_W = 4,
  parameter  int unsigned CNT_W  = 16,
  localparam int unsigned PAR_W  = calc_par_w(DATA_W),
  localparam int unsigned POS_W  = DATA_W + PAR_W,
  localparam int unsigned CODE_W = POS_W + SECDED_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CODE_W-1:0] out_code,
  output logic [CNT_W-1:0]  word_cnt
);

  logic              s1_valid;
  logic [DATA_W-1:0] s1_data;
  logic              s1_adv;
  logic              s2_adv;
  logic [POS_W-1:0]  pos_code;
  logic [CODE_W-1:0] code_next;

  assign s2_adv   = !out_valid || out_ready;
  assign s1_adv   = !s1_valid || s2_adv;
  assign in_ready = s1_adv;

  hamming_parity_gen #(.DATA_W(DATA_W)) u_parity_gen (
    .data   (s1_data),
    .code_c (pos_code)
  );

`ifdef HAMMING_SECDED_EN
  assign code_next = {^pos_code, pos_code};
`else
  assign code_next = pos_code;
`endif

  // S1: capture input word; an empty slot also absorbs bubbles while stalled
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      if (in_valid) s1_data <= in_data;
    end
  end

  // S2: register codeword; held stable while downstream stalls
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_code  <= '0;
    end else if (s2_adv) begin
      out_valid <= s1_valid;
      if (s1_valid) out_code <= code_next;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      word_cnt <= '0;
    end else if (out_valid && out_ready) begin
      word_cnt <= word_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hamming_enc_stream.sv
// Self-checking bench: fixed vectors on a 4-bit encoder, scoreboarded
// backpressure / reset / wrap sequences, exhaustive 11-bit sweep.
module tb_hamming_enc_stream;

`ifdef HAMMING_SECDED_EN
  localparam int unsigned EXT_W = 1;
`else
  localparam int unsigned EXT_W = 0;
`endif
  localparam int unsigned C4  = 7 + EXT_W;
  localparam int unsigned C11 = 15 + EXT_W;

  logic           clk;
  logic           reset;
  logic           in_valid4, in_ready4, out_valid4, out_ready4;
  logic [3:0]     in_data4;
  logic [C4-1:0]  out_code4;
  logic [3:0]     word_cnt4;
  logic           in_valid11, in_ready11, out_valid11, out_ready11;
  logic [10:0]    in_data11;
  logic [C11-1:0] out_code11;
  logic [15:0]    word_cnt11;

  int n_checks = 0;
  int n_fail   = 0;
  bit sb_en    = 0;
  bit rnd_en   = 0;
  int pops11   = 0;
  logic [63:0] q4[$];
  logic [63:0] q11[$];

  typedef struct {
    logic [3:0] data;
    logic [7:0] code;
  } vec_t;
  vec_t tbl [5];

  hamming_enc_stream #(.DATA_W(4), .CNT_W(4)) u_dut4 (
    .clk(clk), .reset(reset), .in_valid(in_valid4), .in_ready(in_ready4),
    .in_data(in_data4), .out_valid(out_valid4), .out_ready(out_ready4),
    .out_code(out_code4), .word_cnt(word_cnt4)
  );

  hamming_enc_stream #(.DATA_W(11), .CNT_W(16)) u_dut11 (
    .clk(clk), .reset(reset), .in_valid(in_valid11), .in_ready(in_ready11),
    .in_data(in_data11), .out_valid(out_valid11), .out_ready(out_ready11),
    .out_code(out_code11), .word_cnt(word_cnt11)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: data in non-power-of-two slots, parity bits = syndrome of data positions
  function automatic logic [63:0] ref_code(input logic [63:0] d, input int dw, input int pw);
    logic [63:0] c;
    int idx;
    int syn;
    c = '0;
    idx = 0;
    syn = 0;
    for (int pos = 1; pos <= dw + pw; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        c[pos-1] = d[idx];
        if (d[idx]) syn = syn ^ pos;
        idx++;
      end
    end
    for (int k = 0; k < pw; k++) c[(1 << k) - 1] = ((syn >> k) & 1) != 0;
    if (EXT_W == 1) c[dw+pw] = ^c;
    return c;
  endfunction

  function automatic int syndrome(input logic [63:0] c, input int n);
    int s;
    s = 0;
    for (int i = 0; i < n; i++) if (c[i]) s = s ^ (i + 1);
    return s;
  endfunction

  always @(negedge clk) begin
    int sz;
    if (!reset && sb_en) begin
      sz = q4.size();
      if (out_valid4) begin
        n_checks++;
        if (q4.size() == 0) begin
          n_fail++;
          $display("FAIL dut4 out_valid with nothing in flight: code %0h", out_code4);
        end else begin
          check("dut4 code", 64'(out_code4), q4[0]);
          if (out_ready4) void'(q4.pop_front());
        end
      end
      check("dut4 in_ready", 64'(in_ready4), 64'(!(sz == 2 && !out_ready4)));
      if (in_valid4 && in_ready4) q4.push_back(ref_code(64'(in_data4), 4, 3));
    end
  end

  always @(negedge clk) begin
    if (!reset && sb_en) begin
      if (out_valid11) begin
        n_checks++;
        if (q11.size() == 0) begin
          n_fail++;
          $display("FAIL dut11 out_valid with nothing in flight: code %0h", out_code11);
        end else begin
          check("dut11 code", 64'(out_code11), q11[0]);
          if (out_ready11) begin
            void'(q11.pop_front());
            if (pops11 % 256 == 0) begin
              check("dut11 clean syndrome", 64'(syndrome(64'(out_code11), 15)), 0);
              for (int b = 0; b < 15; b++)
                check("dut11 flip syndrome",
                      64'(syndrome(64'(out_code11) ^ (64'd1 << b), 15)), 64'(b + 1));
            end
            pops11++;
          end
        end
      end
      if (in_valid11 && in_ready11) q11.push_back(ref_code(64'(in_data11), 11, 4));
    end
  end

  always @(posedge clk) begin
    if (rnd_en) begin
      #1;
      out_ready4 = 1'($urandom_range(0, 1));
    end
  end

  task automatic send4(input logic [3:0] d);
    bit ok;
    int g;
    g = 0;
    in_valid4 = 1'b1;
    in_data4  = d;
    do begin
      @(negedge clk);
      ok = in_ready4;
      @(posedge clk);
      #1;
      g++;
    end while (!ok && g < 100);
    if (!ok) begin
      n_checks++;
      n_fail++;
      $display("FAIL send4 timeout: in_ready stuck at %0b, required 1", in_ready4);
    end
  endtask

  task automatic send11(input logic [10:0] d);
    bit ok;
    int g;
    g = 0;
    in_valid11 = 1'b1;
    in_data11  = d;
    do begin
      @(negedge clk);
      ok = in_ready11;
      @(posedge clk);
      #1;
      g++;
    end while (!ok && g < 100);
    if (!ok) begin
      n_checks++;
      n_fail++;
      $display("FAIL send11 timeout: in_ready stuck at %0b, required 1", in_ready11);
    end
  endtask

  task automatic drain();
    int g;
    g = 0;
    while ((q4.size() != 0 || q11.size() != 0) && g < 300) begin
      @(posedge clk);
      #2;
      g++;
    end
    check("drain q4 empty", 64'(q4.size()), 0);
    check("drain q11 empty", 64'(q11.size()), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "watchdog");
  end

  initial begin
`ifdef HAMMING_SECDED_EN
    tbl = '{'{4'hB, 8'h55}, '{4'hF, 8'hFF}, '{4'h0, 8'h00}, '{4'h1, 8'h87}, '{4'h8, 8'h4B}};
`else
    tbl = '{'{4'hB, 8'h55}, '{4'hF, 8'h7F}, '{4'h0, 8'h00}, '{4'h1, 8'h07}, '{4'h8, 8'h4B}};
`endif
    reset       = 1'b1;
    in_valid4   = 1'b0;
    in_data4    = '0;
    out_ready4  = 1'b1;
    in_valid11  = 1'b0;
    in_data11   = '0;
    out_ready11 = 1'b1;

    #2;
    check("reset out_valid4", 64'(out_valid4), 0);
    check("reset out_code4", 64'(out_code4), 0);
    check("reset word_cnt4", 64'(word_cnt4), 0);
    check("reset out_valid11", 64'(out_valid11), 0);
    #10 reset = 1'b0;
    @(posedge clk);
    #1;
    check("in_ready after reset", 64'(in_ready4), 1);

    // Fixed vectors with latency: word visible on the second edge after it is offered
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      in_valid4 = 1'b1;
      in_data4  = tbl[i].data;
      @(posedge clk);
      #1;
      in_valid4 = 1'b0;
      @(negedge clk);
      check("vec out_valid early", 64'(out_valid4), 0);
      @(posedge clk);
      @(negedge clk);
      check("vec out_valid", 64'(out_valid4), 1);
      check("vec out_code", 64'(out_code4), 64'(tbl[i].code));
    end
    @(posedge clk);
    #1;
    check("word_cnt after vectors", 64'(word_cnt4), 5);

    // Backpressure: 16 words under random out_ready
    sb_en  = 1'b1;
    rnd_en = 1'b1;
    for (int i = 0; i < 16; i++) send4(4'(i));
    in_valid4 = 1'b0;
    drain();
    rnd_en = 1'b0;
    @(posedge clk);
    #1;
    out_ready4 = 1'b1;
    check("word_cnt after backpressure", 64'(word_cnt4), 5);

    // Reset mid-stream with words in both stages
    for (int i = 0; i < 3; i++) send4(4'(i + 3));
    in_valid4 = 1'b0;
    #3 reset = 1'b1;
    #1;
    check("midreset out_valid4", 64'(out_valid4), 0);
    check("midreset word_cnt4", 64'(word_cnt4), 0);
    q4.delete();
    q11.delete();
    #9 reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("no stale word after reset", 64'(out_valid4), 0);
    end

    // Counter wrap: 17 words on a 4-bit counter
    @(posedge clk);
    #1;
    for (int i = 0; i < 17; i++) send4(4'(i));
    in_valid4 = 1'b0;
    drain();
    check("word_cnt wrap", 64'(word_cnt4), 1);

    // Exhaustive 11-bit sweep
    for (int i = 0; i < 2048; i++) send11(11'(i));
    in_valid11 = 1'b0;
    drain();
    check("word_cnt11 total", 64'(word_cnt11), 2048);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
